// File: rtl/lcd_pkg.sv
// Shared constants for the LCD power-up sequencer: ROM entry layout, entry kinds, FSM encoding.
package lcd_pkg;

    localparam int unsigned ENTRY_W = 10;

    localparam logic [1:0] KIND_CMD   = 2'd0;
    localparam logic [1:0] KIND_DATA  = 2'd1;
    localparam logic [1:0] KIND_DELAY = 2'd2;
    localparam logic [1:0] KIND_END   = 2'd3;

    localparam logic [2:0] ST_RST_ASSERT = 3'd0;
    localparam logic [2:0] ST_RST_WAIT   = 3'd1;
    localparam logic [2:0] ST_FETCH      = 3'd2;
    localparam logic [2:0] ST_SEND       = 3'd3;
    localparam logic [2:0] ST_DELAY      = 3'd4;
    localparam logic [2:0] ST_STREAM     = 3'd5;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] payload;
    } rom_entry_t;

    // Longest interval any counter must hold, in ms (DELAY payload can reach 255).
    function automatic int unsigned cnt_max_ms(input int unsigned low_ms,
                                               input int unsigned wait_ms);
        int unsigned m;
        m = 255;
        if (low_ms > m)  m = low_ms;
        if (wait_ms > m) m = wait_ms;
        return m;
    endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// Panel init script as a case table; registered output, unused addresses read as END.
module lcd_init_rom
    import lcd_pkg::*;
#(
    parameter int unsigned AW = 5
) (
    input  logic               clk,
    input  logic [AW-1:0]      addr,
    output logic [ENTRY_W-1:0] data
);

    logic [ENTRY_W-1:0] entry;

    always_comb begin
        entry = {KIND_END, 8'h00};
        case (32'(addr))
            0:       entry = {KIND_CMD,   8'h11};  // sleep out
            1:       entry = {KIND_DELAY, 8'd2};
            2:       entry = {KIND_DATA,  8'h3A};
            3:       entry = {KIND_DELAY, 8'd0};
            4:       entry = {KIND_CMD,   8'h36};
            5:       entry = {KIND_DATA,  8'hC8};
            6:       entry = {KIND_CMD,   8'h29};  // display on
            default: entry = {KIND_END,   8'h00};
        endcase
    end

    always_ff @(posedge clk) begin
        data <= entry;
    end

endmodule

// File: rtl/lcd_init_seq.sv
// LCD power-up sequencer: reset pulse, ROM replay, then pixel stream pass-through.
// Optional stall timeout with full re-init is enabled by defining LCD_SEQ_TIMEOUT_EN.
module lcd_init_seq
    import lcd_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 25_000_000,
    parameter int unsigned ROM_DEPTH   = 32,
    parameter int unsigned RST_LOW_MS  = 10,
    parameter int unsigned RST_WAIT_MS = 120,
    parameter int unsigned TIMEOUT_CYC = 65536
) (
    input  logic       clk,
    input  logic       reset,
    output logic       lcd_rst,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_byte,
    output logic       out_rs,
    input  logic       pix_valid,
    output logic       pix_ready,
    input  logic [7:0] pix_byte,
    input  logic       pix_rs,
    output logic       init_done,
    output logic       busy,
    output logic       err
);

    localparam int unsigned MS_CYC       = CLK_HZ / 1000;
    localparam int unsigned AW           = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
    localparam int unsigned CNT_MAX      = cnt_max_ms(RST_LOW_MS, RST_WAIT_MS) * MS_CYC;
    localparam int unsigned CW           = $clog2(CNT_MAX + 1);
    localparam int unsigned RST_LOW_CYC  = RST_LOW_MS * MS_CYC;
    localparam int unsigned RST_WAIT_CYC = RST_WAIT_MS * MS_CYC;
    localparam logic [AW:0] ADDR_END     = (AW + 1)'(ROM_DEPTH);

    logic [2:0]         state_q, state_d;
    logic [AW:0]        addr_q, addr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [CW-1:0]      delay_last;
    logic [AW-1:0]      rom_addr;
    logic [ENTRY_W-1:0] rom_data;
    rom_entry_t         entry;
    logic               timeout_hit;

    // ROM is addressed with the next address so its registered output always matches addr_q.
    assign rom_addr   = reset ? '0 : addr_d[AW-1:0];
    assign entry      = rom_entry_t'(rom_data);
    assign delay_last = CW'(32'(entry.payload) * MS_CYC - 1);

    lcd_init_rom #(
        .AW(AW)
    ) u_rom (
        .clk (clk),
        .addr(rom_addr),
        .data(rom_data)
    );

`ifdef LCD_SEQ_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] stall_q, stall_d;
    logic          err_q;

    assign timeout_hit = (state_q == ST_SEND) && !out_ready &&
                         (stall_q == TW'(TIMEOUT_CYC - 1));
    assign stall_d     = ((state_q == ST_SEND) && !out_ready) ? stall_q + 1'b1 : '0;
    assign err         = err_q | timeout_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            stall_q <= timeout_hit ? '0 : stall_d;
            if (timeout_hit) err_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q + 1'b1;
        case (state_q)
            ST_RST_ASSERT: begin
                if (cnt_q == CW'(RST_LOW_CYC - 1)) begin
                    state_d = ST_RST_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_RST_WAIT: begin
                if (cnt_q == CW'(RST_WAIT_CYC - 1)) begin
                    state_d = ST_FETCH;
                    cnt_d   = '0;
                end
            end
            ST_FETCH: begin
                cnt_d = '0;
                if (addr_q >= ADDR_END) begin
                    state_d = ST_STREAM;
                end else begin
                    case (entry.kind)
                        KIND_CMD, KIND_DATA: state_d = ST_SEND;
                        KIND_DELAY: begin
                            // Zero-length delay skips straight to the next entry.
                            if (entry.payload == 8'd0) addr_d = addr_q + 1'b1;
                            else                       state_d = ST_DELAY;
                        end
                        default: state_d = ST_STREAM;
                    endcase
                end
            end
            ST_SEND: begin
                cnt_d = '0;
                if (out_ready) begin
                    addr_d  = addr_q + 1'b1;
                    state_d = ST_FETCH;
                end else if (timeout_hit) begin
                    addr_d  = '0;
                    state_d = ST_RST_ASSERT;
                end
            end
            ST_DELAY: begin
                if (cnt_q == delay_last) begin
                    addr_d  = addr_q + 1'b1;
                    state_d = ST_FETCH;
                    cnt_d   = '0;
                end
            end
            ST_STREAM: cnt_d = '0;
            default: begin
                state_d = ST_RST_ASSERT;
                addr_d  = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RST_ASSERT;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        lcd_rst   = (state_q != ST_RST_ASSERT);
        out_valid = 1'b0;
        out_byte  = 8'h00;
        out_rs    = 1'b0;
        pix_ready = 1'b0;
        init_done = 1'b0;
        busy      = 1'b1;
        case (state_q)
            ST_SEND: begin
                out_valid = 1'b1;
                out_byte  = entry.payload;
                out_rs    = entry.kind[0];
            end
            ST_STREAM: begin
                out_valid = pix_valid;
                out_byte  = pix_byte;
                out_rs    = pix_rs;
                pix_ready = out_ready;
                init_done = 1'b1;
                busy      = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lcd_init_seq.sv
// Directed/randomized bench for lcd_init_seq against a transaction-level model of the init script.
module tb_lcd_init_seq;

    localparam int MS = 4;  // CLK_HZ=4000
    localparam int LOW_CYC = 2 * MS;
    localparam int WAIT_CYC = 3 * MS;
    localparam int TMO = 16;
    localparam int NENT = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       lcd_rst, out_valid, out_rs, pix_ready, init_done, busy, err;
    logic       out_ready = 1'b0, pix_valid = 1'b0, pix_rs = 1'b0;
    logic [7:0] out_byte, pix_byte = 8'h00;

    int total = 0;
    int bad = 0;

    // Init script: kind 0=CMD 1=DATA 2=DELAY 3=END
    int rom_kind [NENT] = '{0, 2, 1, 2, 0, 1, 0, 3};
    int rom_pay  [NENT] = '{8'h11, 2, 8'h3A, 0, 8'h36, 8'hC8, 8'h29, 0};

    always #5 clk = ~clk;

    lcd_init_seq #(
        .CLK_HZ     (4000),
        .ROM_DEPTH  (32),
        .RST_LOW_MS (2),
        .RST_WAIT_MS(3),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .lcd_rst  (lcd_rst),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_byte (out_byte),
        .out_rs   (out_rs),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .pix_byte (pix_byte),
        .pix_rs   (pix_rs),
        .init_done(init_done),
        .busy     (busy),
        .err      (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rdy);
        @(negedge clk);
        out_ready = rdy;
        pix_valid = 1'($urandom);
        pix_byte  = 8'($urandom);
        pix_rs    = 1'($urandom);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        out_ready = 1'b1;
        pix_valid = 1'b1;
        pix_byte  = 8'($urandom);
        @(negedge clk);
        #1;
        chk("rst_lcd_rst", 32'(lcd_rst), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_byte", 32'(out_byte), 0);
        chk("rst_out_rs", 32'(out_rs), 0);
        chk("rst_pix_ready", 32'(pix_ready), 0);
        chk("rst_init_done", 32'(init_done), 0);
        chk("rst_busy", 32'(busy), 1);
        chk("rst_err", 32'(err), 0);
        reset = 1'b0;
    endtask

    // Checks from the current cycle (first RST_ASSERT cycle) through init_done.
    // mode: 0 full, 1 stop in SEND of byte 2, 2 stop mid-DELAY before byte 1, 3 stall byte 0.
    task automatic run_init(input int smax, input int first_stall, input int mode,
                            input logic exp_err);
        int idle;
        int nbyte;
        int s;
        for (int c = 0; c < LOW_CYC + WAIT_CYC; c++) begin
            if (c > 0) step(1'($urandom));
            chk("pwr_lcd_rst", 32'(lcd_rst), 32'(c >= LOW_CYC));
            chk("pwr_out_valid", 32'(out_valid), 0);
            chk("pwr_pix_ready", 32'(pix_ready), 0);
            chk("pwr_busy", 32'(busy), 1);
            chk("pwr_err", 32'(err), 32'(exp_err));
        end
        idle  = 1;
        nbyte = 0;
        for (int i = 0; i < NENT; i++) begin
            if (rom_kind[i] == 2) begin
                idle += rom_pay[i] * MS + 1;
            end else begin
                for (int k = 0; k < idle; k++) begin
                    step(1'($urandom));
                    chk("gap_out_valid", 32'(out_valid), 0);
                    chk("gap_pix_ready", 32'(pix_ready), 0);
                    chk("gap_init_done", 32'(init_done), 0);
                    chk("gap_lcd_rst", 32'(lcd_rst), 1);
                    if (mode == 2 && nbyte == 1 && k == 5) return;
                end
                if (rom_kind[i] == 3) begin
                    step(1'($urandom));
                    chk("end_init_done", 32'(init_done), 1);
                    chk("end_busy", 32'(busy), 0);
                    chk("end_err", 32'(err), 32'(exp_err));
                    return;
                end
                if (mode == 3) begin
                    for (int j = 1; j <= TMO; j++) begin
                        step(1'b0);
                        chk("tmo_out_valid", 32'(out_valid), 1);
                        chk("tmo_err", 32'(err), 32'(j == TMO));
                    end
                    return;
                end
                s = (nbyte == 0 && first_stall >= 0) ? first_stall : $urandom_range(smax, 0);
                for (int j = 0; j <= s; j++) begin
                    step(j == s);
                    chk("send_out_valid", 32'(out_valid), 1);
                    chk("send_out_byte", 32'(out_byte), 32'(rom_pay[i]));
                    chk("send_out_rs", 32'(out_rs), 32'(rom_kind[i]));
                    chk("send_pix_ready", 32'(pix_ready), 0);
                    chk("send_busy", 32'(busy), 1);
                    if (mode == 1 && nbyte == 2) begin
                        out_ready = 1'b0;
                        return;
                    end
                end
                idle = 1;
                nbyte++;
            end
        end
    endtask

    task automatic run_stream(input int n, input logic exp_err);
        for (int i = 0; i < n; i++) begin
            step(1'($urandom));
            chk("str_out_valid", 32'(out_valid), 32'(pix_valid));
            chk("str_out_byte", 32'(out_byte), 32'(pix_byte));
            chk("str_out_rs", 32'(out_rs), 32'(pix_rs));
            chk("str_pix_ready", 32'(pix_ready), 32'(out_ready));
            chk("str_init_done", 32'(init_done), 1);
            chk("str_busy", 32'(busy), 0);
            chk("str_err", 32'(err), 32'(exp_err));
        end
        @(negedge clk);
        pix_valid = 1'b1;
        pix_byte  = 8'hAB;
        pix_rs    = 1'b1;
        for (int i = 0; i < 6; i++) begin
            out_ready = 1'(i & 1);
            #1;
            chk("ab_out_byte", 32'(out_byte), 32'hAB);
            chk("ab_out_rs", 32'(out_rs), 1);
            chk("ab_pix_ready", 32'(pix_ready), 32'(i & 1));
            @(negedge clk);
        end
    endtask

    initial begin
        do_reset();
        run_init(3, 5, 0, 1'b0);
        run_stream(24, 1'b0);

        do_reset();
        run_init(2, -1, 1, 1'b0);
        do_reset();
        run_init(0, -1, 2, 1'b0);
        do_reset();
        run_init(4, -1, 0, 1'b0);
        run_stream(12, 1'b0);

`ifdef LCD_SEQ_TIMEOUT_EN
        do_reset();
        run_init(0, -1, 3, 1'b0);
        step(1'b1);
        run_init(3, -1, 0, 1'b1);
        run_stream(8, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
